uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `uart_tx` transmitter among `2**ID_W` byte producers, such as perceptron result, debug and status sources. It accepts one byte at a time from a requester using a valid/ready handshake. It then drives the transmitter's `start`/`data` pair with the required one-cycle data hold, and tracks `busy` through the complete frame before granting again. It sits directly between the producers and the single `uart_tx` instance driving the board's TX pin.

## Interface
- `ID_W`, default 2: requester index width; `N_REQ = 2**ID_W` requesters. Legal range is 1..4.
- `clk`  in  1: single clock, shared with `uart_tx`.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  N_REQ: bit i means requester i holds a byte to send.
- `req_data`  in  8*N_REQ: byte i is `req_data[8*i+7:8*i]`. It must stay stable while `req_valid[i]` is high and `req_ready[i]` is low.
- `req_ready`  out  N_REQ: one-hot, one-cycle accept pulse. The byte transfers when valid and ready are both high.
- `tx_busy`  in  1: `busy` from `uart_tx`.
- `tx_start`  out  1: one-cycle `start` pulse to `uart_tx`.
- `tx_data`  out  8: `data` to `uart_tx`, driven from an internal register.
- `grant_id`  out  ID_W: index of the requester currently being served.
- `active`  out  1: high from accept until the frame sequence completes.

## Operation
- States: IDLE, START, HOLD, WAIT_HI, WAIT_LO.
- IDLE:
  - If any `req_valid` is set and `tx_busy`=0, the winner is the first set bit searched from `last+1`, wrapping N_REQ-1→0.
  - `req_ready[winner]`=1 combinationally in this cycle.
  - On the edge: `req_data` byte → payload register, `grant_id`/`last` ← winner, go to START.
  - If `tx_busy`=1, no grant is made and the state holds.
- START: `tx_start`=1 and `tx_data`=frame byte; next state HOLD.
- HOLD: `tx_start`=0, `tx_data` unchanged; next state WAIT_HI.
- WAIT_HI: stay until `tx_busy`=1, then go to WAIT_LO.
- WAIT_LO: stay until `tx_busy`=0, then go to the next frame's START, or to IDLE if the sequence is done.
- `tx_data` holds its value from START until the next frame's START. It never changes mid-frame.
- `active`=1 in every state except IDLE.
- `req_ready` is 0 outside IDLE. A `req_valid` that deasserts before being granted is simply dropped from arbitration.
- Fairness: after granting i, requester i has the lowest priority. With all requesters valid, grants rotate 0,1,2,3,0…
- Reset values: state IDLE, `tx_start`=0, `tx_data`=8'h00, `req_ready`=0, `grant_id`=0, `active`=0, `last`=N_REQ-1 (so requester 0 has first priority).

## Timing
- Accept at edge T (IDLE cycle): `tx_start`=1 during cycle T+1 and `tx_data` is valid from T+1 onward.
- `uart_tx` samples `start` at the end of T+1 and loads `data` at the end of T+2. HOLD guarantees `data` is stable across both edges.
- `tx_busy` rises in cycle T+2, so WAIT_HI exits after one cycle.
- Earliest next accept: the first IDLE cycle after `tx_busy` falls, which is one cycle after WAIT_LO sees 0.
- Only one byte is in flight at a time; there is no buffering.
- Reset mid-sequence: at the next edge, state is IDLE and `tx_start`=0. The in-flight byte is abandoned and `last` returns to N_REQ-1. No re-send occurs, even if `tx_busy` is still high. The next grant waits for `tx_busy`=0.

## Configuration
- Macro `UART_ARB_HEADER_EN`.
- Defined: each accepted byte produces two frames.
  - First frame: header byte `8'hA0 | grant_id`, with `grant_id` zero-extended into bits [3:0].
  - Second frame: the payload.
  - WAIT_LO after the header frame goes to START with `tx_data` set to the payload. `active` stays high across both frames.
- Undefined: one frame per accepted byte carrying only the payload. No header logic is built.

## Test plan
Bench configuration: `ID_W`=2, paired with a real `uart_tx` instance with `clock_frequency`=12 and `baud_rate`=1.
- Single request: `req_valid`=4'b0100 with byte 2 = 8'h5A → `req_ready`=4'b0100 for one cycle. `tx_start` pulses in the next cycle and `grant_id`=2. The decoded line shows 0x5A (with the header macro, 0xA2 then 0x5A). `active` falls after `tx_busy` falls.
- All requesting: `req_valid`=4'b1111 with bytes 8'h10/8'h11/8'h12/8'h13 held → transmitted order is 0x10, 0x11, 0x12, 0x13, then 0x10 again.
- Wrap-around: requester 3 is served, then `req_valid`=4'b1001 → requester 0 is granted next, then 3.
- Busy gating: force `tx_busy`=1 while in IDLE with `req_valid`=4'b0001 → no `req_ready` and no `tx_start` until `tx_busy`=0. The grant then happens in the first cycle `tx_busy` is low.
- Data hold: payload 8'hC3, and requester 0 changes its byte to 8'h00 right after `req_ready` → `tx_data` stays 8'hC3 across START, HOLD and the whole frame, and the line shows 0xC3.
- Reset mid-frame: assert `rst` for one cycle during WAIT_LO → at the next edge state is IDLE, `tx_start`=0, `active`=0 and `grant_id`=0. The next grant goes to requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one uart_tx among
// 2**ID_W byte producers. Each accepted byte is sent as a uart_tx frame
// with a start pulse and a HOLD cycle, so data is stable while uart_tx
// loads it. No new grant is made until busy has fallen.
//
// Optional feature macro: UART_ARB_HEADER_EN
//   defined   -> every accepted byte goes out as two frames:
//                header (8'hA0 | grant_id), then the payload
//   undefined -> one payload frame per accepted byte, no header logic
//
// ID_W legal range is 1..4, so the grant index fits in the header nibble.
module uart_tx_arbiter #(
    parameter  int ID_W  = 2,
    localparam int N_REQ = 2**ID_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    output logic [N_REQ-1:0]   req_ready_o,
    input  logic               tx_busy_i,
    output logic               tx_start_o,
    output logic [7:0]         tx_data_o,
    output logic [ID_W-1:0]    grant_id_o,
    output logic               active_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_HOLD,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] last_q, last_d;      // most recently granted requester
    logic [ID_W-1:0] grant_q, grant_d;
    logic [7:0]      tx_data_q, tx_data_d;

`ifdef UART_ARB_HEADER_EN
    localparam logic [7:0] HDR_BASE = 8'hA0;
    logic [7:0]      payload_q, payload_d; // byte held back while header is sent
    logic            second_q, second_d;   // payload frame of the pair is in flight
`endif

    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] win_idx;
    logic            win_found;
    logic [7:0]      win_byte;

    // Round-robin search: start one past the last winner and wrap. The
    // index is ID_W bits wide, so the addition wraps N_REQ-1 -> 0 on its own.
    // The final step (k == N_REQ) lands back on last_q, so it has the lowest priority.
    always_comb begin
        cand      = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = last_q + ID_W'(k);
            if (!win_found && req_valid_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign win_byte = req_data_i[{win_idx, 3'b000} +: 8];

    // Sequencer: next-state and handshake outputs
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_d     = grant_q;
        tx_data_d   = tx_data_q;
        req_ready_o = '0;
        tx_start_o  = 1'b0;
`ifdef UART_ARB_HEADER_EN
        payload_d   = payload_q;
        second_d    = second_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                // busy still high (e.g. a frame left over after reset) blocks any grant
                if (win_found && !tx_busy_i) begin
                    req_ready_o[win_idx] = 1'b1;
                    grant_d              = win_idx;
                    last_d               = win_idx;
                    state_d              = S_START;
`ifdef UART_ARB_HEADER_EN
                    payload_d            = win_byte;
                    tx_data_d            = HDR_BASE | 8'(win_idx);
                    second_d             = 1'b0;
`else
                    tx_data_d            = win_byte;
`endif
                end
            end
            S_START: begin
                tx_start_o = 1'b1;
                state_d    = S_HOLD;
            end
            // keeps tx_data steady over the edge where uart_tx loads it
            S_HOLD: begin
                state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (tx_busy_i) begin
                    state_d = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!tx_busy_i) begin
`ifdef UART_ARB_HEADER_EN
                    if (!second_q) begin
                        second_d  = 1'b1;
                        tx_data_d = payload_q;
                        state_d   = S_START;
                    end else begin
                        state_d   = S_IDLE;
                    end
`else
                    state_d = S_IDLE;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset points the rotation at requester 0
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            last_q    <= '1;
            grant_q   <= '0;
            tx_data_q <= 8'h00;
`ifdef UART_ARB_HEADER_EN
            payload_q <= 8'h00;
            second_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            tx_data_q <= tx_data_d;
`ifdef UART_ARB_HEADER_EN
            payload_q <= payload_d;
            second_q  <= second_d;
`endif
        end
    end

    assign tx_data_o  = tx_data_q;
    assign grant_id_o = grant_q;
    assign active_o   = (state_q != S_IDLE);

endmodule
